// File: rtl/fifo_enq_arbiter_if.sv
// Handshake bundle between NREQ ready/valid requesters, the enqueue arbiter and the fifo enqueue port.
// The master view belongs to the arbiter; the slave view belongs to the requesters plus fifo.
interface fifo_enq_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int LOG_NREQ = 2
);
    localparam int NREQ = 1 << LOG_NREQ;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;

    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [LOG_NREQ-1:0]   out_src;
    logic                  out_ready;

    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/fifo_enq_arbiter.sv
// Packet-atomic round-robin arbiter sharing one fifo enqueue port among NREQ requesters.
//
// state | meaning
// IDLE  | no packet in flight; grant is a round-robin scan starting at ptr
// LOCK  | port held by owner until it delivers a beat with last=1
module fifo_enq_arbiter #(
    parameter int WIDTH    = 32,
    parameter int LOG_NREQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    fifo_enq_arbiter_if.master  bus,
    output logic                busy,
    output logic [15:0]         pkt_count
);
    localparam int NREQ = 1 << LOG_NREQ;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LOG_NREQ-1:0] owner_q, owner_d;
    logic [LOG_NREQ-1:0] ptr_q, ptr_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [LOG_NREQ-1:0] sel;
    logic [LOG_NREQ-1:0] idx;
    logic                sel_valid;
    logic                sel_last;
    logic                fire;
    logic [WIDTH-1:0]    data_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = bus.req_data[i*WIDTH +: WIDTH];
        end
    end

    // Grant selection; out_ready is deliberately absent so valid/data/src never depend on it.
    always_comb begin
        sel       = ptr_q;
        idx       = ptr_q;
        sel_valid = 1'b0;
        if (state_q == LOCK) begin
            sel       = owner_q;
            sel_valid = bus.req_valid[owner_q];
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = ptr_q + LOG_NREQ'(k);
                if (!sel_valid && bus.req_valid[idx]) begin
                    sel_valid = 1'b1;
                    sel       = idx;
                end
            end
        end
    end

    assign sel_last = bus.req_last[sel];
    assign fire     = sel_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    if (fire && sel_last) begin
                        ptr_d = sel + LOG_NREQ'(1);
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        // a stalled first beat also locks, keeping the fifo's view stable
                        state_d = LOCK;
                        owner_d = sel;
                    end
                end
            end
            LOCK: begin
                if (fire && sel_last) begin
                    state_d = IDLE;
                    ptr_d   = owner_q + LOG_NREQ'(1);
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (fire) begin
            bus.req_ready[sel] = 1'b1;
        end
        bus.out_valid = sel_valid;
        bus.out_data  = data_arr[sel];
        bus.out_src   = sel;
        busy          = (state_q == LOCK);
        pkt_count     = cnt_q;
    end
endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter: scripted scenarios plus a randomized run against a queue-based fifo model.
module tb_fifo_enq_arbiter;
    localparam int WIDTH    = 32;
    localparam int LOG_NREQ = 2;
    localparam int NREQ     = 4;
    localparam int DEPTH    = 8;
    localparam int NITEMS   = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] pkt_count;
    int          total = 0;
    int          bad   = 0;

    fifo_enq_arbiter_if #(.WIDTH(WIDTH), .LOG_NREQ(LOG_NREQ)) bus();

    fifo_enq_arbiter #(.WIDTH(WIDTH), .LOG_NREQ(LOG_NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input bit v, input logic [31:0] d, input bit l);
        bus.req_valid[i]               = v;
        bus.req_data[i*WIDTH +: WIDTH] = d;
        bus.req_last[i]                = l;
    endtask

    task automatic clear_all();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        total++; if (bus.out_src !== 2'd0) begin bad++; $display("FAIL reset_out_src got=%0d exp=0", bus.out_src); end
        cyc();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 32'(1000 + i), 1'b1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            total++; if (bus.out_src !== 2'(k % 4)) begin bad++; $display("FAIL rr_src k=%0d got=%0d exp=%0d", k, bus.out_src, k % 4); end
            total++; if (bus.out_data !== 32'(1000 + k % 4)) begin bad++; $display("FAIL rr_data k=%0d got=%0d exp=%0d", k, bus.out_data, 1000 + k % 4); end
            total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.req_ready, exp_rdy); end
            cyc();
        end
        total++; if (pkt_count !== 16'd8) begin bad++; $display("FAIL rr_pkt_count got=%0d exp=8", pkt_count); end
        clear_all();
    endtask

    task automatic test_atomicity();
        // one packet from req0 alone moves the pointer to 1
        drive(0, 1'b1, 32'd1000, 1'b1);
        cyc();
        drive(2, 1'b1, 32'd1002, 1'b1);
        for (int b = 0; b < 3; b++) begin
            drive(1, 1'b1, 32'(2000 + b), (b == 2));
            #1;
            total++; if (bus.out_src !== 2'd1) begin bad++; $display("FAIL atom_src b=%0d got=%0d exp=1", b, bus.out_src); end
            total++; if (bus.out_data !== 32'(2000 + b)) begin bad++; $display("FAIL atom_data b=%0d got=%0d exp=%0d", b, bus.out_data, 2000 + b); end
            total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL atom_ready b=%0d got=%b exp=0010", b, bus.req_ready); end
            total++; if (busy !== (b != 0)) begin bad++; $display("FAIL atom_busy b=%0d got=%b exp=%b", b, busy, (b != 0)); end
            cyc();
        end
        drive(1, 1'b0, 32'd0, 1'b0);
        #1;
        total++; if (pkt_count !== 16'd10) begin bad++; $display("FAIL atom_pkt_count got=%0d exp=10", pkt_count); end
        total++; if (bus.out_src !== 2'd2) begin bad++; $display("FAIL atom_next2 got=%0d exp=2", bus.out_src); end
        cyc();
        total++; if (bus.out_src !== 2'd0) begin bad++; $display("FAIL atom_next0 got=%0d exp=0", bus.out_src); end
        cyc();
        clear_all();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(3, 1'b1, 32'd4000, 1'b1);
        drive(0, 1'b1, 32'd1000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (bus.out_src !== 2'd3) begin bad++; $display("FAIL bp_src k=%0d got=%0d exp=3", k, bus.out_src); end
            total++; if (bus.out_data !== 32'd4000) begin bad++; $display("FAIL bp_data k=%0d got=%0d exp=4000", k, bus.out_data); end
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready k=%0d got=%b exp=0000", k, bus.req_ready); end
            total++; if (busy !== (k != 0)) begin bad++; $display("FAIL bp_busy k=%0d got=%b exp=%b", k, busy, (k != 0)); end
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release got=%b exp=1000", bus.req_ready); end
        cyc();
        drive(3, 1'b0, 32'd0, 1'b0);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next0 got=%b exp=0001", bus.req_ready); end
        cyc();
        clear_all();
    endtask

    task automatic test_owner_gap();
        drive(2, 1'b1, 32'd3000, 1'b0);
        #1;
        total++; if (bus.out_src !== 2'd2) begin bad++; $display("FAIL gap_first_src got=%0d exp=2", bus.out_src); end
        cyc();
        drive(2, 1'b0, 32'd0, 1'b0);
        drive(1, 1'b1, 32'd1001, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL gap_valid k=%0d got=%b exp=0", k, bus.out_valid); end
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL gap_ready k=%0d got=%b exp=0000", k, bus.req_ready); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy k=%0d got=%b exp=1", k, busy); end
            cyc();
        end
        drive(2, 1'b1, 32'd3001, 1'b1);
        #1;
        total++; if (bus.out_data !== 32'd3001) begin bad++; $display("FAIL gap_resume_data got=%0d exp=3001", bus.out_data); end
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL gap_resume_ready got=%b exp=0100", bus.req_ready); end
        cyc();
        drive(2, 1'b0, 32'd0, 1'b0);
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL gap_next1 got=%b exp=0010", bus.req_ready); end
        cyc();
        clear_all();
        total++; if (pkt_count !== 16'd16) begin bad++; $display("FAIL gap_pkt_count got=%0d exp=16", pkt_count); end
    endtask

    task automatic test_reset_mid_packet();
        cyc();
        drive(2, 1'b1, 32'd3100, 1'b0);
        cyc();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_locked got=%b exp=1", busy); end
        clear_all();
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL rmid_pkt_count got=%0d exp=0", pkt_count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus.out_valid); end
        drive(0, 1'b1, 32'd1000, 1'b1);
        drive(2, 1'b1, 32'd1002, 1'b1);
        cyc();
        rst = 1'b0;
        #1;
        total++; if (bus.out_src !== 2'd0) begin bad++; $display("FAIL rmid_ptr_src got=%0d exp=0", bus.out_src); end
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ptr_ready got=%b exp=0001", bus.req_ready); end
        cyc();
        clear_all();
    endtask

    task automatic test_concurrency();
        logic [31:0] items [NREQ][$];
        logic [31:0] fifo_q [$];
        bit          pres [NREQ];
        int          wcnt [NREQ];
        int          received = 0;
        int          cycles   = 0;
        int          s;
        bit          drain, fire, anyp;
        rst = 1'b1;
        clear_all();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin pres[i] = 1'b0; wcnt[i] = 0; end
        for (int n = 0; n < NITEMS; n++) begin
            s = int'($urandom_range(0, NREQ - 1));
            items[s].push_back(32'(s << 16) | 32'(n));
        end
        while (received < NITEMS && cycles < 3000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pres[i] && items[i].size() > 0 && $urandom_range(0, 1) == 1) begin
                    pres[i] = 1'b1;
                    drive(i, 1'b1, items[i][0], 1'b1);
                end
            end
            drain = ($urandom_range(0, 2) != 0);
            bus.out_ready = (fifo_q.size() < DEPTH);
            #1;
            anyp = 1'b0;
            for (int i = 0; i < NREQ; i++) anyp |= pres[i];
            total++; if (bus.out_valid !== anyp) begin bad++; $display("FAIL conc_valid cyc=%0d got=%b exp=%b", cycles, bus.out_valid, anyp); end
            total++; if ($countones(bus.req_ready) > 1) begin bad++; $display("FAIL conc_onehot cyc=%0d got=%b exp=at_most_one", cycles, bus.req_ready); end
            fire = bus.out_valid && bus.out_ready;
            if (drain && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (fire) begin
                s = int'(bus.out_src);
                total++;
                if (!pres[s] || items[s].size() == 0 || bus.out_data !== items[s][0]) begin
                    bad++; $display("FAIL conc_order src=%0d got=%h exp=%h", s, bus.out_data, (items[s].size() > 0) ? items[s][0] : 32'hx);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (i != s && pres[i]) begin
                        wcnt[i]++;
                        total++; if (wcnt[i] > NREQ - 1) begin bad++; $display("FAIL conc_fair req=%0d got=%0d exp<=%0d", i, wcnt[i], NREQ - 1); end
                    end
                end
                wcnt[s] = 0;
                fifo_q.push_back(bus.out_data);
                if (items[s].size() > 0) void'(items[s].pop_front());
                received++;
            end
            cyc();
            if (fire) begin
                pres[s] = 1'b0;
                drive(s, 1'b0, 32'd0, 1'b0);
            end
            cycles++;
        end
        total++; if (received != NITEMS) begin bad++; $display("FAIL conc_received got=%0d exp=%0d", received, NITEMS); end
        total++; if (pkt_count !== 16'(NITEMS)) begin bad++; $display("FAIL conc_pkt_count got=%0d exp=%0d", pkt_count, NITEMS); end
        clear_all();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_atomicity();
        test_backpressure();
        test_owner_gap();
        test_reset_mid_packet();
        test_concurrency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
